// File: rtl/dt_infer_pkg.sv
// Shared definitions for the decision-tree inference engine: FSM states, derived widths,
// node-word field offsets and child-field decode.
package dt_infer_pkg;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StMac, StCmp, StDone} state_e;

  localparam int unsigned ChildMaxW = 32;
  localparam int unsigned ChildFw   = ChildMaxW + 1;

  typedef struct packed {
    logic                 leaf;
    logic [ChildMaxW-1:0] ptr;
  } child_t;

  function automatic int unsigned calc_acc_w(input int unsigned n_attr, input int unsigned attr_w,
                                             input int unsigned w_w);
    return attr_w + w_w + $clog2(n_attr);
  endfunction

  function automatic int unsigned calc_ptr_w(input int unsigned node_aw,
                                             input int unsigned class_w);
    return (node_aw > class_w) ? node_aw : class_w;
  endfunction

  function automatic int unsigned calc_node_w(input int unsigned n_attr, input int unsigned w_w,
                                              input int unsigned acc_w, input int unsigned ptr_w);
    return n_attr * w_w + acc_w + 2 * (ptr_w + 1);
  endfunction

  // Right child sits at bit 0; fields above it stack upward towards the weights.
  function automatic int unsigned left_off(input int unsigned ptr_w);
    return ptr_w + 1;
  endfunction

  function automatic int unsigned thr_off(input int unsigned ptr_w);
    return 2 * (ptr_w + 1);
  endfunction

  function automatic int unsigned w_off(input int unsigned ptr_w, input int unsigned acc_w);
    return 2 * (ptr_w + 1) + acc_w;
  endfunction

  // Field arrives zero-extended; the leaf flag is the bit just above the ptr_w-wide pointer.
  function automatic child_t decode_child(input logic [ChildMaxW:0] field,
                                          input int unsigned ptr_w);
    child_t               c;
    logic [ChildMaxW:0]   sh;
    logic [ChildMaxW-1:0] mask;
    sh     = field >> ptr_w;
    mask   = ~({ChildMaxW{1'b1}} << ptr_w);
    c.leaf = sh[0];
    c.ptr  = field[ChildMaxW-1:0] & mask;
    return c;
  endfunction

endpackage

// File: rtl/dt_node_ram.sv
// Single-port synchronous node table: one-cycle read latency, a write takes the port that cycle.
module dt_node_ram #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dt_infer_engine.sv
// Oblique decision-tree walker: per node a serial MAC over the attributes, then a threshold branch.
// Optional o_path_len output enabled by defining DT_INFER_PATHLEN_EN.
module dt_infer_engine
  import dt_infer_pkg::*;
#(
  parameter int unsigned N_ATTR    = 4,
  parameter int unsigned ATTR_W    = 8,
  parameter int unsigned W_W       = 8,
  parameter int unsigned NODE_AW   = 5,
  parameter int unsigned CLASS_W   = 8,
  parameter int unsigned MAX_DEPTH = 16,
  localparam int unsigned ACC_W    = calc_acc_w(N_ATTR, ATTR_W, W_W),
  localparam int unsigned PTR_W    = calc_ptr_w(NODE_AW, CLASS_W),
  localparam int unsigned NODE_W   = calc_node_w(N_ATTR, W_W, ACC_W, PTR_W),
  localparam int unsigned STEP_W   = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cfg_we,
  input  logic [NODE_AW-1:0]       i_cfg_addr,
  input  logic [NODE_W-1:0]        i_cfg_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [N_ATTR*ATTR_W-1:0] i_attr,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [CLASS_W-1:0]       o_class,
  output logic                     o_err,
  output logic                     o_busy
`ifdef DT_INFER_PATHLEN_EN
  ,
  output logic [STEP_W-1:0]        o_path_len
`endif
);

  localparam int unsigned IDX_W   = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
  localparam int unsigned L_OFF   = left_off(PTR_W);
  localparam int unsigned THR_OFF = thr_off(PTR_W);
  localparam int unsigned W_OFF   = w_off(PTR_W, ACC_W);
  localparam logic [STEP_W-1:0] MaxSteps = STEP_W'(MAX_DEPTH);
  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(N_ATTR - 1);

  state_e                     state_q, state_d;
  logic [N_ATTR*ATTR_W-1:0]   attr_q, attr_d;
  logic [NODE_AW-1:0]         addr_q, addr_d;
  logic [NODE_W-1:0]          node_q, node_d;
  logic [ACC_W-1:0]           acc_q, acc_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [STEP_W-1:0]          step_q, step_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic                       err_q, err_d;

  logic                       ram_we;
  logic [NODE_AW-1:0]         ram_addr;
  logic [NODE_W-1:0]          ram_rdata;

  // Table writes only land while idle; a same-cycle accept then reads the fresh word.
  assign ram_we   = i_cfg_we && (state_q == StIdle);
  assign ram_addr = ram_we ? i_cfg_addr : addr_q;

  dt_node_ram #(
    .AW (NODE_AW),
    .DW (NODE_W)
  ) u_node_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (i_cfg_data),
    .rdata_o (ram_rdata)
  );

  logic [ATTR_W-1:0] attr_sel;
  logic [W_W-1:0]    w_sel;
  logic [ACC_W-1:0]  prod;

  always_comb begin
    attr_sel = '0;
    w_sel    = '0;
    for (int k = 0; k < N_ATTR; k++) begin
      if (idx_q == IDX_W'(k)) begin
        attr_sel = attr_q[k*ATTR_W +: ATTR_W];
        w_sel    = node_q[W_OFF + k*W_W +: W_W];
      end
    end
  end

  assign prod = ACC_W'(attr_sel) * ACC_W'(w_sel);

  logic [ACC_W-1:0] thr;
  logic             go_left;
  child_t           child;
  logic             unused_ptr;

  assign thr        = node_q[THR_OFF +: ACC_W];
  assign go_left    = (acc_q <= thr);
  assign child      = decode_child(ChildFw'(go_left ? node_q[L_OFF +: PTR_W+1]
                                                    : node_q[PTR_W:0]), PTR_W);
  assign unused_ptr = ^child.ptr;

  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    addr_d  = addr_q;
    node_d  = node_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    step_d  = step_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          attr_d  = i_attr;
          addr_d  = '0;
          acc_d   = '0;
          step_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        node_d  = ram_rdata;
        idx_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        acc_d = acc_q + prod;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StCmp;
      end
      StCmp: begin
        step_d = step_q + 1'b1;
        if (child.leaf) begin
          class_d = child.ptr[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (step_d == MaxSteps) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          addr_d  = child.ptr[NODE_AW-1:0];
          acc_d   = '0;
          state_d = StFetch;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      attr_q  <= '0;
      addr_q  <= '0;
      node_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      step_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      attr_q  <= attr_d;
      addr_q  <= addr_d;
      node_q  <= node_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  assign o_ready = (state_q == StIdle);
  assign o_busy  = (state_q != StIdle);
  assign o_valid = (state_q == StDone);
  assign o_class = class_q;
  assign o_err   = err_q;

`ifdef DT_INFER_PATHLEN_EN
  assign o_path_len = step_q;
`endif

endmodule

// File: tb/tb_dt_infer_engine.sv
// Directed bench for dt_infer_engine: vector table over a two-node tree plus corner sequences.
module tb_dt_infer_engine;

  localparam int unsigned NodeW  = 68;
  localparam int unsigned StepW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_cfg_we;
  logic [4:0]        i_cfg_addr;
  logic [NodeW-1:0]  i_cfg_data;
  logic              i_valid;
  logic              o_ready;
  logic [31:0]       i_attr;
  logic              o_valid;
  logic              i_ready;
  logic [7:0]        o_class;
  logic              o_err;
  logic              o_busy;
`ifdef DT_INFER_PATHLEN_EN
  logic [StepW-1:0]  o_path_len;
`endif

  dt_infer_engine #(
    .N_ATTR    (4),
    .ATTR_W    (8),
    .W_W       (8),
    .NODE_AW   (5),
    .CLASS_W   (8),
    .MAX_DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cfg_we   (i_cfg_we),
    .i_cfg_addr (i_cfg_addr),
    .i_cfg_data (i_cfg_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_attr     (i_attr),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_class    (o_class),
    .o_err      (o_err),
    .o_busy     (o_busy)
`ifdef DT_INFER_PATHLEN_EN
    ,
    .o_path_len (o_path_len)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned cycle_cnt = 0;
  int unsigned t0        = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [31:0] attr;
    logic [7:0]  cls;
    logic        err;
    int          cyc;
    int          len;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Node word layout: w3 w2 w1 w0 | thr(18) | left{leaf,ptr8} | right{leaf,ptr8}
  function automatic logic [NodeW-1:0] mk_node(input logic [7:0] w3, input logic [7:0] w2,
                                               input logic [7:0] w1, input logic [7:0] w0,
                                               input logic [17:0] thr,
                                               input logic ll, input logic [7:0] lp,
                                               input logic rl, input logic [7:0] rp);
    return {w3, w2, w1, w0, thr, ll, lp, rl, rp};
  endfunction

  task automatic cfg_write(input logic [4:0] addr, input logic [NodeW-1:0] data);
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_data = data;
    @(negedge clk);
    i_cfg_we   = 1'b0;
  endtask

  task automatic accept(input logic [31:0] attr);
    @(negedge clk);
    i_valid = 1'b1;
    i_attr  = attr;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    t0      = cycle_cnt;
  endtask

  task automatic wait_result(input string name, input logic [7:0] exp_cls, input logic exp_err,
                             input int exp_cyc, input int exp_len, input int hold);
    int cyc;
    cyc = int'(cycle_cnt - t0) + 1;
    while (!o_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc = int'(cycle_cnt - t0) + 1;
    end
    check({name, ".valid"}, 32'(o_valid), 32'd1);
    check({name, ".latency"}, 32'(cyc), 32'(exp_cyc));
    check({name, ".class"}, 32'(o_class), 32'(exp_cls));
    check({name, ".err"}, 32'(o_err), 32'(exp_err));
    check({name, ".ready_low"}, 32'(o_ready), 32'd0);
`ifdef DT_INFER_PATHLEN_EN
    check({name, ".path_len"}, 32'(o_path_len), 32'(exp_len));
`else
    if (exp_len < 0) $display("note: negative path length in %s", name);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({name, ".hold_valid"}, 32'(o_valid), 32'd1);
      check({name, ".hold_class"}, 32'(o_class), 32'(exp_cls));
      check({name, ".hold_err"}, 32'(o_err), 32'(exp_err));
      check({name, ".hold_ready"}, 32'(o_ready), 32'd0);
    end
    @(negedge clk);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    check({name, ".post_valid"}, 32'(o_valid), 32'd0);
    check({name, ".post_ready"}, 32'(o_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [NodeW-1:0] node0;
    logic [NodeW-1:0] node1;

    node0 = mk_node(8'd1, 8'd1, 8'd1, 8'd1, 18'd100, 1'b1, 8'd3, 1'b0, 8'd1);
    node1 = mk_node(8'd0, 8'd0, 8'd0, 8'd2, 18'd50, 1'b1, 8'd5, 1'b1, 8'd7);

    // attr packed as {a3,a2,a1,a0}
    vecs[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, 8'd3, 1'b0, 8, 1};
    vecs[1] = '{{8'd40, 8'd40, 8'd40, 8'd40}, 8'd7, 1'b0, 15, 2};
    vecs[2] = '{{8'd30, 8'd30, 8'd30, 8'd20}, 8'd5, 1'b0, 15, 2};
    vecs[3] = '{{8'd0, 8'd0, 8'd0, 8'd0}, 8'd3, 1'b0, 8, 1};
    vecs[4] = '{{8'd25, 8'd25, 8'd25, 8'd25}, 8'd3, 1'b0, 8, 1};
    vecs[5] = '{{8'd26, 8'd25, 8'd25, 8'd25}, 8'd5, 1'b0, 15, 2};
    vecs[6] = '{{8'd25, 8'd25, 8'd25, 8'd26}, 8'd7, 1'b0, 15, 2};
    vecs[7] = '{{8'd255, 8'd255, 8'd255, 8'd255}, 8'd7, 1'b0, 15, 2};

    rst_n      = 1'b0;
    i_cfg_we   = 1'b0;
    i_cfg_addr = '0;
    i_cfg_data = '0;
    i_valid    = 1'b0;
    i_attr     = '0;
    i_ready    = 1'b0;
    #1;
    check("reset.ready", 32'(o_ready), 32'd1);
    check("reset.valid", 32'(o_valid), 32'd0);
    check("reset.class", 32'(o_class), 32'd0);
    check("reset.err", 32'(o_err), 32'd0);
    check("reset.busy", 32'(o_busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cfg_write(5'd0, node0);
    cfg_write(5'd1, node1);

    for (int v = 0; v < 8; v++) begin
      accept(vecs[v].attr);
      check($sformatf("vec%0d.busy", v), 32'(o_busy), 32'd1);
      wait_result($sformatf("vec%0d", v), vecs[v].cls, vecs[v].err, vecs[v].cyc, vecs[v].len, 0);
    end

    // Backpressure: result held for 10 cycles with i_ready low.
    accept({8'd40, 8'd40, 8'd40, 8'd40});
    wait_result("backpressure", 8'd7, 1'b0, 15, 2, 10);

    // Write while busy must not reach the table.
    accept({8'd40, 8'd40, 8'd40, 8'd40});
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = 5'd1;
    i_cfg_data = mk_node(8'd0, 8'd0, 8'd0, 8'd0, 18'd0, 1'b1, 8'd9, 1'b1, 8'd9);
    @(negedge clk);
    i_cfg_we   = 1'b0;
    wait_result("busy_write", 8'd7, 1'b0, 15, 2, 0);
    accept({8'd40, 8'd40, 8'd40, 8'd40});
    wait_result("busy_write_rerun", 8'd7, 1'b0, 15, 2, 0);

    // Self-loop on node0: depth guard trips after 8 nodes.
    cfg_write(5'd0, mk_node(8'd1, 8'd1, 8'd1, 8'd1, 18'd100, 1'b1, 8'd3, 1'b0, 8'd0));
    accept({8'd255, 8'd255, 8'd255, 8'd255});
    wait_result("depth_guard", 8'd0, 1'b1, 57, 8, 0);

    // Restore node0 in the same cycle as the accept; the sample must see the new word.
    @(negedge clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = 5'd0;
    i_cfg_data = node0;
    i_valid    = 1'b1;
    i_attr     = {8'd40, 8'd40, 8'd40, 8'd40};
    @(posedge clk);
    #1;
    i_cfg_we = 1'b0;
    i_valid  = 1'b0;
    t0       = cycle_cnt;
    wait_result("write_and_accept", 8'd7, 1'b0, 15, 2, 0);

    // Reset during MAC aborts the inference.
    accept({8'd40, 8'd40, 8'd40, 8'd40});
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset.ready", 32'(o_ready), 32'd1);
    check("midreset.valid", 32'(o_valid), 32'd0);
    check("midreset.class", 32'(o_class), 32'd0);
    check("midreset.err", 32'(o_err), 32'd0);
    check("midreset.busy", 32'(o_busy), 32'd0);
`ifdef DT_INFER_PATHLEN_EN
    check("midreset.path_len", 32'(o_path_len), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (o_valid) seen++;
    end
    check("midreset.no_result", 32'(seen), 32'd0);

    accept({8'd40, 8'd30, 8'd20, 8'd10});
    wait_result("post_reset", 8'd3, 1'b0, 8, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt_infer_engine.md
# dt_infer_engine

Parametrised decision-tree inference engine for the BDD accelerator. It walks a tree of oblique nodes held in an on-chip node table. At each node it computes a weighted sum of N_ATTR attributes, compares the sum against the node threshold, and branches left or right until it reaches a leaf, then returns that leaf's class. It generalises the fixed-width single-tree datapath to configurable attribute count, widths and table depth, and adds valid/ready handshakes, table loading, a depth guard and an error flag.

## Interface
- N_ATTR, 4: attributes per sample and weights per node
- ATTR_W, 8: attribute width, unsigned
- W_W, 8: weight width, unsigned
- NODE_AW, 5: node-table address width; depth is 2**NODE_AW
- CLASS_W, 8: class label width
- MAX_DEPTH, 16: maximum nodes visited per inference
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_cfg_we  in  1  node-table write strobe
- i_cfg_addr  in  NODE_AW  node-table write address
- i_cfg_data  in  NODE_W  node word, layout per package
- i_valid  in  1  sample valid
- o_ready  out  1  engine can accept a sample
- i_attr  in  N_ATTR*ATTR_W  attributes, attr[0] in the LSBs
- o_valid  out  1  result valid
- i_ready  in  1  consumer accepts result
- o_class  out  CLASS_W  leaf class
- o_err  out  1  depth guard tripped (qualified by o_valid)
- o_busy  out  1  inference in progress

## Operation
- Derived widths:
  - ACC_W = ATTR_W+W_W+$clog2(N_ATTR)
  - PTR_W = max(NODE_AW, CLASS_W)
  - child field = {leaf, ptr[PTR_W-1:0]}
- Node word, MSB to LSB: w[N_ATTR-1]..w[0], thr (ACC_W), left child, right child.
- FSM states: IDLE, FETCH, WAIT, MAC, CMP, DONE.
  - IDLE: o_ready=1. The cycle in which i_valid&&o_ready is high latches i_attr, sets node address 0, clears acc and the step count, and moves to FETCH.
  - FETCH: drives the table read address. Next state WAIT.
  - WAIT: the synchronous read returns. Latch the node word and go to MAC.
  - MAC: one product per cycle, acc += attr[k]*w[k] for k=0..N_ATTR-1, taking N_ATTR cycles. Arithmetic is unsigned at full ACC_W width and cannot overflow.
  - CMP: if acc <= thr take the left child, else the right child. Increment the step count.
    - Selected child has leaf=1: o_class=ptr[CLASS_W-1:0], o_err=0, go to DONE.
    - Else, if step count == MAX_DEPTH: o_class=0, o_err=1, go to DONE.
    - Else: node address = ptr[NODE_AW-1:0], acc cleared, go to FETCH.
  - DONE: o_valid=1. o_class and o_err stay stable until i_ready. On the handshake, go to IDLE.
- Table writes are honoured only in IDLE. In any other state they are ignored and the table is unchanged.
- A write and a sample accept in the same IDLE cycle: the write completes first, so the new sample sees the new table.
- Table contents are not reset.
- Reset values: o_ready=1 (IDLE), o_valid=0, o_class=0, o_err=0, o_busy=0.
- Reset asserted mid-inference aborts it immediately. No result is produced.

## Timing
- Cost per visited node: N_ATTR+3 cycles (FETCH, WAIT, N_ATTR MAC cycles, CMP).
- For an accept edge at cycle 0 and D nodes visited, o_valid rises at cycle D*(N_ATTR+3)+1.
- o_busy = state != IDLE.
- o_ready is low from the accept edge until the cycle after the DONE handshake. There is one inference in flight at a time.
- Throughput is capped by this, so there is no zero-bubble back-to-back acceptance.

## Configuration
- DT_INFER_PATHLEN_EN defined: adds output o_path_len, width $clog2(MAX_DEPTH+1).
  - It holds the number of nodes visited.
  - It is valid with o_valid and resets to 0.
- DT_INFER_PATHLEN_EN undefined: the port and its counter logic are absent. All other behaviour is identical.

## Structure
- Package dt_infer_pkg holds:
  - state enum
  - width functions (ACC_W, PTR_W, NODE_W)
  - node-field offset functions
  - the child-field struct
- Sub-module dt_node_ram: single-port synchronous RAM, 1-cycle read latency, write has priority. Top-level owns the FSM, MAC and compare.

## Test plan
All scenarios use N_ATTR=4, ATTR_W=8, W_W=8, MAX_DEPTH=8 and this table:
- node0: w={1,1,1,1}, thr=100, left=leaf 3, right=node 1
- node1: w attr0=2 (others 0), thr=50, left=leaf 5, right=leaf 7

Scenarios:
- attr={10,20,30,40} → sum 100 ≤ 100 → o_class=3, o_err=0, o_valid at cycle 8.
- attr={40,40,40,40} → node0 sum 160 → node1 sum 80 > 50 → o_class=7 at cycle 15. With DT_INFER_PATHLEN_EN defined, o_path_len=2.
- attr={20,30,30,30} → node1 sum 40 → o_class=5.
- node0 right child rewritten to node 0, attr={255,255,255,255} → after 8 nodes o_valid=1, o_err=1, o_class=0.
- Backpressure and config-while-busy:
  - Hold i_ready=0 for 10 cycles after o_valid. o_class and o_err stay stable and o_ready stays 0.
  - A cfg write issued while busy leaves the table unchanged, checked by a rerun giving the same class.
- Reset and post-reset behaviour:
  - Assert rst_n=0 during MAC. The outputs take their reset values asynchronously and no o_valid follows.
  - A new sample after reset completes normally against the retained table.
